// File: rtl/mxnbit_and_nand_nor.sv
// Registered lane-wise AND/NAND/NOR over SETS packed lanes of WIDTH bits, one-cycle latency.
// Optional per-lane all-zero flag on the AND result: define MXNBIT_LANE_FLAGS_EN.
module mxnbit_and_nand_nor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SETS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [SETS*WIDTH-1:0] in1_packed,
  input  logic [SETS*WIDTH-1:0] in2_packed,
  output logic [SETS*WIDTH-1:0] and_out_packed,
  output logic [SETS*WIDTH-1:0] nand_out_packed,
  output logic [SETS*WIDTH-1:0] nor_out_packed,
`ifdef MXNBIT_LANE_FLAGS_EN
  output logic [SETS-1:0]       and_zero,
`endif
  output logic                  out_valid
);

  localparam int unsigned Bits = SETS * WIDTH;

  logic [Bits-1:0] and_d, and_q;
  logic [Bits-1:0] nand_d, nand_q;
  logic [Bits-1:0] nor_d, nor_q;
  logic            valid_d, valid_q;

  // Bitwise ops never cross bit positions, so lanes stay independent by construction.
  always_comb begin
    and_d   = and_q;
    nand_d  = nand_q;
    nor_d   = nor_q;
    valid_d = in_valid;
    if (in_valid) begin
      and_d  = in1_packed & in2_packed;
      nand_d = ~(in1_packed & in2_packed);
      nor_d  = ~(in1_packed | in2_packed);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_q   <= '0;
      nand_q  <= '0;
      nor_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      and_q   <= and_d;
      nand_q  <= nand_d;
      nor_q   <= nor_d;
      valid_q <= valid_d;
    end
  end

  assign and_out_packed  = and_q;
  assign nand_out_packed = nand_q;
  assign nor_out_packed  = nor_q;
  assign out_valid       = valid_q;

`ifdef MXNBIT_LANE_FLAGS_EN
  logic [SETS-1:0] zero_d, zero_q;

  always_comb begin
    zero_d = zero_q;
    if (in_valid) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        zero_d[i] = ~|(in1_packed[i*WIDTH +: WIDTH] & in2_packed[i*WIDTH +: WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= '0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign and_zero = zero_q;
`endif

endmodule

// File: tb/tb_mxnbit_and_nand_nor.sv
// Self-checking bench for mxnbit_and_nand_nor: vector table, exhaustive sweep, hold, reset, corners.
// Flag checks follow MXNBIT_LANE_FLAGS_EN.
`timescale 1ns/1ps
module tb_mxnbit_and_nand_nor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] n;
    logic [7:0] o;
    logic [1:0] z;
    logic       v;
  } exp_t;

  typedef struct {
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] e_and;
    logic [7:0] e_nand;
    logic [7:0] e_nor;
    logic [1:0] e_zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in1 = '0, in2 = '0;
  logic [7:0] and_o, nand_o, nor_o;
  logic [1:0] zero_o;
  logic out_valid;

  logic c1_valid = 1'b0;
  logic [0:0] c1_in1 = '0, c1_in2 = '0, c1_and, c1_nand, c1_nor, c1_zero;
  logic c1_ov;
  logic c8_valid = 1'b0;
  logic [31:0] c8_in1 = '0, c8_in2 = '0, c8_and, c8_nand, c8_nor;
  logic [3:0] c8_zero;
  logic c8_ov;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];
  exp_t m;
  vec_t tbl[6];

  always #5 clk = ~clk;

  mxnbit_and_nand_nor #(.WIDTH(4), .SETS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1_packed(in1), .in2_packed(in2),
    .and_out_packed(and_o), .nand_out_packed(nand_o), .nor_out_packed(nor_o),
`ifdef MXNBIT_LANE_FLAGS_EN
    .and_zero(zero_o),
`endif
    .out_valid(out_valid)
  );

  mxnbit_and_nand_nor #(.WIDTH(1), .SETS(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(c1_valid), .in1_packed(c1_in1), .in2_packed(c1_in2),
    .and_out_packed(c1_and), .nand_out_packed(c1_nand), .nor_out_packed(c1_nor),
`ifdef MXNBIT_LANE_FLAGS_EN
    .and_zero(c1_zero),
`endif
    .out_valid(c1_ov)
  );

  mxnbit_and_nand_nor #(.WIDTH(8), .SETS(4)) dut_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(c8_valid), .in1_packed(c8_in1), .in2_packed(c8_in2),
    .and_out_packed(c8_and), .nand_out_packed(c8_nand), .nor_out_packed(c8_nor),
`ifdef MXNBIT_LANE_FLAGS_EN
    .and_zero(c8_zero),
`endif
    .out_valid(c8_ov)
  );

`ifndef MXNBIT_LANE_FLAGS_EN
  assign zero_o  = '0;
  assign c1_zero = '0;
  assign c8_zero = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bit-by-bit reference, lane flag from an explicit per-lane scan.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    for (int l = 0; l < 2; l++) begin
      e.z[l] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        e.a[l*4+k] = a[l*4+k] && b[l*4+k];
        e.n[l*4+k] = !(a[l*4+k] && b[l*4+k]);
        e.o[l*4+k] = !(a[l*4+k] || b[l*4+k]);
        if (e.a[l*4+k]) e.z[l] = 1'b0;
      end
    end
    e.v = 1'b1;
    return e;
  endfunction

  task automatic compare_out(input string tag, input exp_t e);
    chk({tag, ".and"}, {24'd0, and_o}, {24'd0, e.a});
    chk({tag, ".nand"}, {24'd0, nand_o}, {24'd0, e.n});
    chk({tag, ".nor"}, {24'd0, nor_o}, {24'd0, e.o});
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.v});
`ifdef MXNBIT_LANE_FLAGS_EN
    chk({tag, ".and_zero"}, {30'd0, zero_o}, {30'd0, e.z});
`endif
  endtask

  // Drive one cycle; the expected result rides the scoreboard until the DUT shows it.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic v, input logic use_exp, input exp_t given);
    exp_t e;
    @(negedge clk);
    in1 = a;
    in2 = b;
    in_valid = v;
    if (v) m = use_exp ? given : model(a, b);
    e = m;
    e.v = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.scoreboard: got empty, expected entry", tag);
    end else begin
      e = sb.pop_front();
      compare_out(tag, e);
    end
  endtask

  initial begin
    exp_t none;
    none = '{a: 8'h00, n: 8'h00, o: 8'h00, z: 2'b00, v: 1'b0};
    m = none;
    tbl[0] = '{8'h3C, 8'h5A, 8'h18, 8'hE7, 8'h81, 2'b00};
    tbl[1] = '{8'hF0, 8'hFF, 8'hF0, 8'h0F, 8'h00, 2'b01};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 2'b11};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b00};
    tbl[4] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h00, 2'b11};
    tbl[5] = '{8'h0F, 8'h03, 8'h03, 8'hFC, 8'hF0, 2'b10};

    #2 rst_n = 1'b0;
    #1 compare_out("reset", none);
    in_valid = 1'b1;
    in1 = 8'hFF;
    in2 = 8'hFF;
    @(posedge clk);
    #1 compare_out("reset_ignores_in", none);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e = '{a: tbl[i].e_and, n: tbl[i].e_nand, o: tbl[i].e_nor, z: tbl[i].e_zero, v: 1'b1};
      step($sformatf("vec%0d", i), tbl[i].in1, tbl[i].in2, 1'b1, 1'b1, e);
    end

    // Lane 1 walks a bijective permutation so both lanes cover all 256 combos independently.
    for (int k = 0; k < 256; k++) begin
      logic [7:0] j;
      logic [7:0] kk;
      kk = 8'(k);
      j = 8'((k * 37 + 11) % 256);
      step("sweep", {j[3:0], kk[3:0]}, {j[7:4], kk[7:4]}, 1'b1, 1'b0, none);
    end

    step("hold_load", 8'h3C, 8'h5A, 1'b1, 1'b0, none);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold%0d", i), 8'($urandom), 8'($urandom), 1'b0, 1'b0, none);
    end

    step("pre_reset", 8'h0F, 8'h03, 1'b1, 1'b0, none);
    #2 rst_n = 1'b0;
    #1 compare_out("async_reset", none);
    in_valid = 1'b1;
    in1 = 8'hFF;
    in2 = 8'hFF;
    @(posedge clk);
    #1 compare_out("in_reset", none);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 compare_out("post_release", none);
    m = none;
    step("first_after_reset", 8'hF0, 8'hFF, 1'b1, 1'b0, none);

    @(negedge clk);
    c1_valid = 1'b1; c1_in1 = 1'b1; c1_in2 = 1'b1;
    c8_valid = 1'b1; c8_in1 = 32'hFFFF_FFFF; c8_in2 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("c1_ones.and", {31'd0, c1_and}, 32'd1);
    chk("c1_ones.nand", {31'd0, c1_nand}, 32'd0);
    chk("c1_ones.nor", {31'd0, c1_nor}, 32'd0);
    chk("c1_ones.valid", {31'd0, c1_ov}, 32'd1);
    chk("c8_ones.and", c8_and, 32'hFFFF_FFFF);
    chk("c8_ones.nand", c8_nand, 32'd0);
    chk("c8_ones.nor", c8_nor, 32'd0);
    chk("c8_ones.valid", {31'd0, c8_ov}, 32'd1);
`ifdef MXNBIT_LANE_FLAGS_EN
    chk("c1_ones.and_zero", {31'd0, c1_zero}, 32'd0);
    chk("c8_ones.and_zero", {28'd0, c8_zero}, 32'd0);
`endif
    @(negedge clk);
    c1_in1 = 1'b0; c1_in2 = 1'b0;
    c8_in1 = 32'd0; c8_in2 = 32'd0;
    @(posedge clk);
    #1;
    chk("c1_zeros.and", {31'd0, c1_and}, 32'd0);
    chk("c1_zeros.nand", {31'd0, c1_nand}, 32'd1);
    chk("c1_zeros.nor", {31'd0, c1_nor}, 32'd1);
    chk("c8_zeros.and", c8_and, 32'd0);
    chk("c8_zeros.nand", c8_nand, 32'hFFFF_FFFF);
    chk("c8_zeros.nor", c8_nor, 32'hFFFF_FFFF);
    chk("c8_zeros.valid", {31'd0, c8_ov}, 32'd1);
`ifdef MXNBIT_LANE_FLAGS_EN
    chk("c1_zeros.and_zero", {31'd0, c1_zero}, 32'd1);
    chk("c8_zeros.and_zero", {28'd0, c8_zero}, 32'hF);
`endif
    @(negedge clk);
    c1_valid = 1'b0;
    c8_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mxnbit_and_nand_nor.md
MXNBIT_AND_NAND_NOR -- requirements
Module: mxnbit_and_nand_nor

Interface
REQ-001 Parameter WIDTH, default 4: bit width of one operand set (lane); SHALL be >= 1.
REQ-002 Parameter SETS, default 2: number of independent lanes packed per operand; SHALL be >= 1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand words valid this cycle.
REQ-006 in1_packed  input  SETS*WIDTH  operand 1; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in2_packed  input  SETS*WIDTH  operand 2; same lane packing.
REQ-008 and_out_packed  output  SETS*WIDTH  registered lane-wise AND.
REQ-009 nand_out_packed  output  SETS*WIDTH  registered lane-wise NAND.
REQ-010 nor_out_packed  output  SETS*WIDTH  registered lane-wise NOR.
REQ-011 out_valid  output  1  registered results valid.

Function
REQ-012 For each lane i and bit b: and = in1 & in2, nand = ~(in1 & in2), nor = ~(in1 | in2), all bitwise.
REQ-013 Lanes SHALL be fully independent; no bit of lane i affects any other lane.
REQ-014 Latency SHALL be exactly 1 cycle: operands sampled on edge N with in_valid=1 appear on outputs after edge N, with out_valid=1.
REQ-015 Edge with in_valid=0: all three result buses SHALL hold their previous values; out_valid SHALL be 0.
REQ-016 Back-to-back in_valid=1 SHALL give one result per cycle; no stall or backpressure exists.
REQ-017 No arithmetic, carry or width extension; output width SHALL equal input width exactly.
REQ-018 No combinational path from inputs to outputs.

Reset
REQ-019 rst_n low SHALL immediately (without clk) force and_out_packed, nand_out_packed, nor_out_packed to all zeros and out_valid to 0.
REQ-020 While rst_n is low, inputs SHALL be ignored; the first capture occurs on the first rising clk edge with rst_n high.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result; no stale value reappears after release.

Configuration
REQ-022 Macro MXNBIT_LANE_FLAGS_EN: when defined, the module SHALL add output and_zero [SETS-1:0], where bit i = 1 if and-result lane i is all zeros. The output SHALL be registered with the same latency and hold rules as the data and SHALL reset to 0.
REQ-023 Without MXNBIT_LANE_FLAGS_EN, the and_zero port and its logic SHALL NOT exist. All other behaviour SHALL be identical.

Verification (WIDTH=4, SETS=2 unless stated)
REQ-024 in1=8'h3C, in2=8'h5A, in_valid=1 -> next cycle and=8'h18, nand=8'hE7, nor=8'h81, out_valid=1; with flags, and_zero=2'b00.
REQ-025 Exhaustive sweep: each lane of in1 and in2 runs 0..15 (256 combos per lane), one vector per cycle, both lanes varied independently -> every output matches REQ-012 one cycle later.
REQ-026 in1=8'hF0, in2=8'hFF -> and=8'hF0, nand=8'h0F, nor=8'h00; with flags, and_zero=2'b01 (lane isolation).
REQ-027 Apply a valid vector, then in_valid=0 for 3 cycles with changing operands -> outputs hold the last result, out_valid=0.
REQ-028 Drive rst_n low asynchronously between edges while out_valid=1 -> all outputs become 0 at once. After release, the first valid vector yields its correct result after 1 cycle.
REQ-029 Parameter corners WIDTH=1, SETS=1 and WIDTH=8, SETS=4 with all-ones and all-zeros operands -> and/nand/nor equal to all-ones/all-zeros/all-zeros and all-zeros/all-ones/all-ones respectively.
